sel_mux_array: RTL and testbench

- Parameterised-width 2:1 word multiplexer: one select line steers one of two SIZE-bit words to the output.
- The ALU uses it for adder-operand selection (ACC vs ~ACC on SUB) and result selection (adder vs shifter on SHIFT).
- Optional output register (REGISTERED) lets the same block sit on a pipeline boundary.

---
 rtl/sel_mux_array.sv | 46 ++++
 tb/tb_sel_mux_array.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sel_mux_array.sv
// SIZE-bit 2:1 word multiplexer, bit-sliced, with an optional output register
// so the same block can sit on a pipeline boundary.
module sel_mux_array #(
    parameter int SIZE       = 8,
    parameter int REGISTERED = 0
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            sel,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic [SIZE-1:0] o
);

    logic [SIZE-1:0] mux_word;

    // AND/OR form keeps an unknown sel visible as X wherever a and b differ.
    genvar i;
    generate
        for (i = 0; i < SIZE; i++) begin : g_bit
            assign mux_word[i] = (a[i] & ~sel) | (b[i] & sel);
        end
    endgenerate

    generate
        if (REGISTERED != 0) begin : g_reg
            logic [SIZE-1:0] o_q;

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    o_q <= '0;
                end else begin
                    o_q <= mux_word;
                end
            end

            assign o = o_q;
        end else begin : g_comb
            logic unused_clk_rst;

            assign unused_clk_rst = CLK ^ RST_N;
            assign o              = mux_word;
        end
    endgenerate

endmodule

// File: tb/tb_sel_mux_array.sv
// Directed bench for sel_mux_array: combinational SIZE=1/8/16 instances,
// a registered SIZE=8 instance, and the ALU subtract-operand use case.
module tb_sel_mux_array;

    int total = 0;
    int bad   = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic        sel8c;
    logic [7:0]  a8c, b8c, o8c;
    logic        sel8r;
    logic [7:0]  a8r, b8r, o8r;
    logic        sel1;
    logic [0:0]  a1, b1, o1;
    logic        sel16;
    logic [15:0] a16, b16, o16;

    sel_mux_array #(.SIZE(8), .REGISTERED(0)) u_comb8 (
        .CLK(clk), .RST_N(rst_n), .sel(sel8c), .a(a8c), .b(b8c), .o(o8c)
    );

    sel_mux_array #(.SIZE(8), .REGISTERED(1)) u_reg8 (
        .CLK(clk), .RST_N(rst_n), .sel(sel8r), .a(a8r), .b(b8r), .o(o8r)
    );

    sel_mux_array #(.SIZE(1), .REGISTERED(0)) u_comb1 (
        .CLK(clk), .RST_N(rst_n), .sel(sel1), .a(a1), .b(b1), .o(o1)
    );

    sel_mux_array #(.SIZE(16), .REGISTERED(0)) u_comb16 (
        .CLK(clk), .RST_N(rst_n), .sel(sel16), .a(a16), .b(b16), .o(o16)
    );

    task automatic test_reset();
        sel8r = 1'b0;
        a8r   = 8'h5A;
        b8r   = 8'hFF;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (o8r !== 8'h00) begin
            bad++;
            $display("FAIL reset_hold o=%h expected=%h", o8r, 8'h00);
        end
    endtask

    task automatic test_comb_select();
        a8c   = 8'h3C;
        b8c   = 8'hC3;
        sel8c = 1'b0;
        #1;
        total++;
        if (o8c !== 8'h3C) begin
            bad++;
            $display("FAIL comb_sel0 o=%h expected=%h", o8c, 8'h3C);
        end
        sel8c = 1'b1;
        #1;
        total++;
        if (o8c !== 8'hC3) begin
            bad++;
            $display("FAIL comb_sel1 o=%h expected=%h", o8c, 8'hC3);
        end
    endtask

    task automatic test_comb_tracking();
        logic [7:0] bvals [3];
        bvals[0] = 8'h00;
        bvals[1] = 8'hFF;
        bvals[2] = 8'hA5;
        sel8c = 1'b1;
        a8c   = 8'h3C;
        for (int k = 0; k < 3; k++) begin
            b8c = bvals[k];
            #1;
            total++;
            if (o8c !== bvals[k]) begin
                bad++;
                $display("FAIL comb_track_b%0d o=%h expected=%h", k, o8c, bvals[k]);
            end
        end
        a8c = 8'h11;
        #1;
        total++;
        if (o8c !== 8'hA5) begin
            bad++;
            $display("FAIL comb_a_ignored o=%h expected=%h", o8c, 8'hA5);
        end
        a8c = 8'h96;
        b8c = 8'h96;
        for (int s = 0; s < 2; s++) begin
            sel8c = s[0];
            #1;
            total++;
            if (o8c !== 8'h96) begin
                bad++;
                $display("FAIL comb_a_eq_b sel=%0d o=%h expected=%h", s, o8c, 8'h96);
            end
        end
    endtask

    task automatic test_registered();
        @(negedge clk);
        sel8r = 1'b0;
        a8r   = 8'h5A;
        b8r   = 8'h00;
        rst_n = 1'b1;
        #1;
        total++;
        if (o8r !== 8'h00) begin
            bad++;
            $display("FAIL reg_release_no_capture o=%h expected=%h", o8r, 8'h00);
        end
        @(posedge clk);
        #1;
        total++;
        if (o8r !== 8'h5A) begin
            bad++;
            $display("FAIL reg_edge1 o=%h expected=%h", o8r, 8'h5A);
        end
        @(negedge clk);
        sel8r = 1'b1;
        b8r   = 8'h81;
        #1;
        total++;
        if (o8r !== 8'h5A) begin
            bad++;
            $display("FAIL reg_between_edges o=%h expected=%h", o8r, 8'h5A);
        end
        @(posedge clk);
        #1;
        total++;
        if (o8r !== 8'h81) begin
            bad++;
            $display("FAIL reg_edge2 o=%h expected=%h", o8r, 8'h81);
        end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        sel8r = 1'b0;
        a8r   = 8'h33;
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (o8r !== 8'h00) begin
            bad++;
            $display("FAIL reg_async_reset o=%h expected=%h", o8r, 8'h00);
        end
        for (int e = 0; e < 2; e++) begin
            @(posedge clk);
            #1;
            total++;
            if (o8r !== 8'h00) begin
                bad++;
                $display("FAIL reg_reset_held_edge%0d o=%h expected=%h", e, o8r, 8'h00);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (o8r !== 8'h33) begin
            bad++;
            $display("FAIL reg_after_release o=%h expected=%h", o8r, 8'h33);
        end
    endtask

    task automatic test_exhaustive_widths();
        logic [15:0] pats [4];
        logic [15:0] exp16;
        logic [0:0]  exp1;
        pats[0] = 16'h0000;
        pats[1] = 16'hFFFF;
        pats[2] = 16'hAAAA;
        pats[3] = 16'h5555;
        for (int s = 0; s < 2; s++) begin
            for (int ia = 0; ia < 4; ia++) begin
                for (int ib = 0; ib < 4; ib++) begin
                    sel16 = s[0];
                    a16   = pats[ia];
                    b16   = pats[ib];
                    sel1  = s[0];
                    a1    = pats[ia][0];
                    b1    = pats[ib][1];
                    #1;
                    exp16 = (s == 1) ? pats[ib] : pats[ia];
                    exp1  = (s == 1) ? pats[ib][1] : pats[ia][0];
                    total++;
                    if (o16 !== exp16) begin
                        bad++;
                        $display("FAIL w16 sel=%0d a=%h b=%h o=%h expected=%h",
                                 s, pats[ia], pats[ib], o16, exp16);
                    end
                    total++;
                    if (o1 !== exp1) begin
                        bad++;
                        $display("FAIL w1 sel=%0d o=%b expected=%b", s, o1, exp1);
                    end
                end
            end
        end
    endtask

    task automatic test_alu_sub();
        logic [7:0] acc;
        logic [7:0] regv;
        logic       sub;
        logic [8:0] sum;
        acc   = 8'h05;
        regv  = 8'h09;
        sub   = 1'b1;
        sel8c = sub;
        a8c   = acc;
        b8c   = ~acc;
        #1;
        total++;
        if (o8c !== 8'hFA) begin
            bad++;
            $display("FAIL alu_operand o=%h expected=%h", o8c, 8'hFA);
        end
        sum = {1'b0, regv} + {1'b0, o8c} + {8'h00, sub};
        total++;
        if (sum[7:0] !== 8'h04 || sum[8] !== 1'b1) begin
            bad++;
            $display("FAIL alu_result result=%h carry=%b expected result=04 carry=1",
                     sum[7:0], sum[8]);
        end
    endtask

    initial begin
        sel8c = 1'b0; a8c = '0; b8c = '0;
        sel1  = 1'b0; a1  = '0; b1  = '0;
        sel16 = 1'b0; a16 = '0; b16 = '0;
        test_reset();
        test_comb_select();
        test_comb_tracking();
        test_registered();
        test_reset_midstream();
        test_exhaustive_widths();
        test_alu_sub();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
